ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter BUF_BYTES, default 8, prefetch buffer depth in bytes (even, at least 4).
REQ-002 Parameter RESET_PC, default 16'h4000, buffer base address after reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 iread_addr  input  16  byte address of the instruction the CPU consumes this cycle.
REQ-006 iread_data  output  24  instruction window {byte[A+2], byte[A+1], byte[A]}; opcode in [7:0].
REQ-007 ivalid  output  1  iread_data holds all 3 bytes at iread_addr this cycle.
REQ-008 mem_req  output  1  word read request to instruction memory.
REQ-009 mem_addr  output  16  even byte address of the requested word; bit 0 always 0.
REQ-010 mem_ready  input  1  memory accepts the request this cycle when mem_req=1.
REQ-011 mem_rdata  input  16  returned word, little-endian: [7:0] is the byte at the even address.
REQ-012 mem_rvalid  input  1  mem_rdata valid; at most one response per accepted request.

Function
REQ-013 State: base (16, even), count (valid bytes, even, 0..BUF_BYTES), byte storage, FSM {IDLE, REQ, WAIT, DRAIN}.
REQ-014 off = (iread_addr - base) mod 2^16; all address arithmetic wraps mod 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-015 ivalid = (count >= 3) && (off <= count-3), combinational from iread_addr and state, same cycle.
REQ-016 ivalid=1: iread_data = bytes off, off+1, off+2 placed at [7:0], [15:8], [23:16]; ivalid=0: iread_data = 24'h000000.
REQ-017 Wait: off < count+2 with ivalid=0 keeps the buffer; ivalid stays 0 until bytes arrive.
REQ-018 Flush: off >= count+2; at the edge base <= iread_addr & 16'hFFFE, count <= 0.
REQ-019 Retire (no flush): drop d = min(off>>1, count>>1) low words; base += 2d.
REQ-020 Response accepted (mem_rvalid, FSM=WAIT, no flush) appends the word; same-edge count = count - 2d + 2.
REQ-021 mem_req=1 only in REQ, with mem_addr = base + count; mem_addr stays stable until accepted unless a flush occurs.
REQ-022 IDLE->REQ when count <= BUF_BYTES-2 after retire; IDLE otherwise.
REQ-023 REQ->WAIT on mem_ready; a flush in REQ stays in REQ with the new mem_addr next cycle.
REQ-024 WAIT->REQ/IDLE on mem_rvalid per REQ-022; a flush in WAIT -> DRAIN.
REQ-025 A flush coinciding with mem_rvalid discards that word.
REQ-026 DRAIN: mem_req=0; mem_rvalid discarded -> REQ; a further flush stays in DRAIN.
REQ-027 One outstanding request maximum.
REQ-028 Cold-miss latency with mem_ready=1 and 1-cycle rvalid: flush at edge E, ivalid from cycle E+4 for even targets.

Reset
REQ-029 While reset=0: base=RESET_PC, count=0, FSM=IDLE, mem_req=0, ivalid=0, iread_data=0.
REQ-030 Reset mid-request drops any outstanding response; after release the first mem_addr is RESET_PC.
REQ-031 mem_rvalid arriving while FSM is not WAIT or DRAIN is ignored.

Structure
REQ-032 Package ifetch_pkg holds fetch_state_t (IDLE, REQ, WAIT, DRAIN), RESET_PC, and BUF_BYTES default.
REQ-033 One sub-module ifetch_buf holds byte storage with shift-by-2d plus append and a 3-byte read port at off.

Verification
REQ-034 Reset release, iread_addr=16'h4000, memory returns 0x4000..0x4003 = 01,02,03,04 -> ivalid rises, iread_data=24'h030201.
REQ-035 Sequential addrs 4000, 4001, 4003 over buffered data -> windows correct; base retires to 4000, 4000, 4002; no flush.
REQ-036 In WAIT, iread_addr jumps to 16'h5001 -> DRAIN; old rvalid dropped; next mem_addr=16'h5000; first ivalid shows byte 5001 at [7:0].
REQ-037 base=16'hFFFE, bytes FFFE..0001 fetched, iread_addr=16'hFFFF -> mem_addr wraps to 16'h0000; window {b[0001], b[0000], b[FFFF]}.
REQ-038 Buffer full (count=8), iread_addr held -> mem_req stays 0; advancing iread_addr by 2 -> one new request at base+8.
REQ-039 reset asserted in WAIT, mem_rvalid during reset -> count=0 after release; first mem_addr=16'h4000.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction prefetch block.
// The FSM encoding and reset defaults live here so the top and the bench agree.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [15:0] DEF_RESET_PC  = 16'h4000;
  localparam int          DEF_BUF_BYTES = 8;

  function automatic logic [15:0] word_align(input logic [15:0] a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Prefetch byte storage: drops whole low words and appends one word per edge.
// Read window is combinational (0 cycles); no backpressure, the caller owns validity.
module ifetch_buf #(
  parameter int BUF_BYTES = 8,
  parameter int CW        = $clog2(BUF_BYTES + 1)
) (
  input  logic          clk,
  input  logic [CW-1:0] i_drop,
  input  logic          i_app_vld,
  input  logic [CW-1:0] i_app_pos,
  input  logic [15:0]   i_app_dat,
  input  logic [CW-1:0] i_off,
  output logic [23:0]   o_win
);

  logic [7:0] r_mem [BUF_BYTES];
  logic [7:0] w_nxt [BUF_BYTES];

  // Shift down by i_drop bytes, then land the appended word at its post-shift slot.
  always_comb begin
    for (int i = 0; i < BUF_BYTES; i++) begin
      w_nxt[i] = 8'h00;
      for (int j = 0; j < BUF_BYTES; j++) begin
        if (j == i + int'(i_drop)) w_nxt[i] = r_mem[j];
      end
      if (i_app_vld && (i == int'(i_app_pos)))     w_nxt[i] = i_app_dat[7:0];
      if (i_app_vld && (i == int'(i_app_pos) + 1)) w_nxt[i] = i_app_dat[15:8];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_BYTES; i++) r_mem[i] <= w_nxt[i];
  end

  always_comb begin
    o_win = 24'h000000;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < BUF_BYTES; j++) begin
        if (j == int'(i_off) + k) o_win[8*k +: 8] = r_mem[j];
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction prefetcher: 3-byte window at iread_addr, same-cycle hit, word refills.
// Latency: hit is combinational; one outstanding memory read, held until mem_ready.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          BUF_BYTES = DEF_BUF_BYTES,
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] iread_addr,
  output logic [23:0] iread_data,
  output logic        ivalid,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int            CW      = $clog2(BUF_BYTES + 1);
  localparam logic [CW-1:0] REQ_THR = CW'(BUF_BYTES - 2);

  logic [15:0]   r_base;
  logic [CW-1:0] r_count;
  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;

  logic [15:0]   w_off;
  logic [16:0]   w_off_x;
  logic [16:0]   w_cnt_x;
  logic          w_ivalid;
  logic          w_flush;
  logic          w_app;
  logic [CW-1:0] w_drop;
  logic [CW-1:0] w_keep;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   w_base_nxt;
  logic [23:0]   w_win;

  assign w_off   = iread_addr - r_base;
  assign w_off_x = {1'b0, w_off};
  assign w_cnt_x = 17'(r_count);

  assign w_ivalid = (w_cnt_x >= 17'd3) && (w_off_x + 17'd3 <= w_cnt_x);
  assign w_flush  = (w_off_x >= w_cnt_x + 17'd2);

  // Retire whole words below the consumed address; never more than we hold.
  assign w_drop = w_flush              ? '0 :
                  (w_off_x >= w_cnt_x) ? r_count :
                                         {w_off[CW-1:1], 1'b0};
  assign w_keep = r_count - w_drop;

  assign w_app       = mem_rvalid && (r_state == WAIT) && !w_flush;
  assign w_count_nxt = w_flush ? '0 : (w_app ? w_keep + CW'(2) : w_keep);
  assign w_base_nxt  = w_flush ? word_align(iread_addr) : r_base + 16'(w_drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base  <= RESET_PC;
      r_count <= '0;
      r_state <= IDLE;
    end else begin
      r_base  <= w_base_nxt;
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  // A request is withheld during a flush so a stale address is never accepted.
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count_nxt <= REQ_THR) w_state_nxt = REQ;
      end
      REQ: begin
        mem_req = !w_flush;
        if (!w_flush && mem_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)   w_state_nxt = (w_count_nxt <= REQ_THR) ? REQ : IDLE;
        else if (w_flush) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (mem_rvalid) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_addr   = r_base + 16'(r_count);
  assign ivalid     = w_ivalid;
  assign iread_data = w_ivalid ? w_win : 24'h000000;

  ifetch_buf #(
    .BUF_BYTES (BUF_BYTES),
    .CW        (CW)
  ) u_buf (
    .clk       (clk),
    .i_drop    (w_drop),
    .i_app_vld (w_app),
    .i_app_pos (w_keep),
    .i_app_dat (mem_rdata),
    .i_off     (w_off[CW-1:0]),
    .o_win     (w_win)
  );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: queue-based reference model, directed scenarios, random traffic.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int BUF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iread_addr;
  logic [23:0] iread_data;
  logic        ivalid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  always #5 clk = ~clk;

  ifetch #(.BUF_BYTES(BUF), .RESET_PC(16'h4000)) dut (
    .clk        (clk),
    .reset      (reset),
    .iread_addr (iread_addr),
    .iread_data (iread_data),
    .ivalid     (ivalid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  int checks = 0;
  int errors = 0;

  // reference model: held bytes as a queue plus request bookkeeping
  logic [15:0] m_base;
  logic [7:0]  m_q[$];
  bit          m_want, m_out, m_stale, m_valid_seen;
  logic [15:0] m_out_addr;

  // instruction memory
  bit          mem_pend;
  int          mem_timer;
  logic [15:0] mem_paddr;
  int          lat;
  bit          rand_lat;
  int          rdy_pct;

  bit          obs_valid, obs_req, saw_addr0;
  logic [23:0] obs_data;
  logic [15:0] obs_addr;

  function automatic logic [7:0] mbyte(input logic [15:0] a);
    return 8'(a[7:0] + 8'd1) ^ 8'(a[15:8] - 8'h40);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_base = 16'h4000;
    m_q.delete();
    m_want = 0;
    m_out = 0;
    m_stale = 0;
    m_out_addr = 16'h0000;
    m_valid_seen = 0;
  endtask

  task automatic model_step();
    int cnt, o, d;
    logic [15:0] off, eaddr;
    logic [23:0] ed;
    bit ev, fl, ereq, rv;
    cnt   = m_q.size();
    off   = iread_addr - m_base;
    o     = int'(off);
    ev    = (cnt >= 3) && (o + 3 <= cnt);
    ed    = ev ? {m_q[o+2], m_q[o+1], m_q[o]} : 24'h000000;
    fl    = (o >= cnt + 2);
    ereq  = m_want && !fl;
    eaddr = m_base + 16'(cnt);
    chk("ivalid", 32'(ivalid), 32'(ev));
    chk("iread_data", 32'(iread_data), 32'(ed));
    chk("mem_req", 32'(mem_req), 32'(ereq));
    if (ereq && mem_req) chk("mem_addr", 32'(mem_addr), 32'(eaddr));
    m_valid_seen = ev;

    rv = mem_rvalid;
    if (fl) begin
      m_q.delete();
      m_base = {iread_addr[15:1], 1'b0};
    end else begin
      d = ((o / 2) < (cnt / 2)) ? (o / 2) : (cnt / 2);
      for (int k = 0; k < 2 * d; k++) void'(m_q.pop_front());
      m_base = m_base + 16'(2 * d);
    end
    if (rv && m_out) begin
      if (!m_stale && !fl) begin
        m_q.push_back(mbyte(m_out_addr));
        m_q.push_back(mbyte(m_out_addr + 16'd1));
      end
      m_out = 0;
    end
    if (m_out && fl) m_stale = 1;
    if (ereq && mem_ready) begin
      m_out = 1;
      m_stale = 0;
      m_out_addr = eaddr;
      m_want = 0;
    end else if (m_out) begin
      m_want = 0;
    end else if (!m_want) begin
      m_want = (m_q.size() <= BUF - 2);
    end
  endtask

  task automatic cycle();
    bit acc;
    logic [15:0] acc_addr;
    @(negedge clk);
    obs_valid = ivalid;
    obs_data  = iread_data;
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    if (mem_req && mem_addr == 16'h0000) saw_addr0 = 1;
    acc      = reset && mem_req && mem_ready;
    acc_addr = mem_addr;
    if (!reset) begin
      model_reset();
      chk("rst_ivalid", 32'(ivalid), 32'd0);
      chk("rst_data", 32'(iread_data), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
    end else begin
      model_step();
    end
    @(posedge clk);
    #1;
    if (acc) begin
      mem_pend  = 1;
      mem_timer = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mem_paddr = acc_addr;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (mem_pend) begin
      mem_timer--;
      if (mem_timer == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {mbyte(mem_paddr + 16'd1), mbyte(mem_paddr)};
        mem_pend   = 0;
      end
    end
    mem_ready = (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  task automatic run_until_valid(input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (obs_valid) break;
    end
    chk(name, 32'(obs_valid), 32'd1);
  endtask

  task automatic run_until_req(input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (obs_req) break;
    end
    chk(name, 32'(obs_req), 32'd1);
  endtask

  initial begin
    logic [15:0] cur;
    int r;
    reset = 1'b0;
    iread_addr = 16'h4000;
    mem_ready = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata = 16'h0000;
    mem_pend = 0;
    mem_timer = 0;
    mem_paddr = 16'h0000;
    lat = 1;
    rand_lat = 0;
    rdy_pct = 100;
    saw_addr0 = 0;
    model_reset();

    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;

    // cold start at the reset address
    run_until_req(10, "first_req");
    chk("first_addr", 32'(obs_addr), 32'h4000);
    run_until_valid(20, "valid_4000");
    chk("win_4000", 32'(obs_data), 32'h030201);

    // sequential consumption
    iread_addr = 16'h4001;
    cycle();
    chk("win_4001", 32'(obs_data), 32'h040302);
    chk("base_4001", 32'(dut.r_base), 32'h4000);
    iread_addr = 16'h4003;
    run_until_valid(20, "valid_4003");
    chk("win_4003", 32'(obs_data), 32'h060504);
    chk("base_4003", 32'(dut.r_base), 32'h4002);

    // full buffer stops fetching; freeing one word refetches at base+8
    for (int i = 0; i < 20; i++) cycle();
    chk("full_req", 32'(obs_req), 32'd0);
    chk("full_count", 32'(dut.r_count), 32'd8);
    lat = 3;
    iread_addr = 16'h4005;
    run_until_req(10, "req_after_free");
    chk("addr_400a", 32'(obs_addr), 32'h400A);

    // jump while waiting: stale word dropped
    iread_addr = 16'h5001;
    cycle();
    chk("drain_state", 32'(dut.r_state), 32'(DRAIN));
    run_until_req(10, "req_5000");
    chk("addr_5000", 32'(obs_addr), 32'h5000);
    run_until_valid(30, "valid_5001");
    chk("win_5001", 32'(obs_data), 32'h141312);

    // address wrap at the top of memory
    lat = 1;
    iread_addr = 16'hFFFE;
    run_until_valid(30, "valid_fffe");
    chk("win_fffe", 32'(obs_data), 32'hC1BF40);
    iread_addr = 16'hFFFF;
    run_until_valid(20, "valid_ffff");
    chk("win_ffff", 32'(obs_data), 32'hC2C1BF);
    chk("wrap_addr0", 32'(saw_addr0), 32'd1);

    // reset while a read is outstanding, response lands during reset
    lat = 3;
    iread_addr = 16'h6000;
    run_until_req(10, "req_6000");
    reset = 1'b0;
    iread_addr = 16'h4000;
    for (int i = 0; i < 4; i++) cycle();
    mem_pend = 0;
    reset = 1'b1;
    cycle();
    chk("rst_count", 32'(dut.r_count), 32'd0);
    run_until_req(10, "req_after_rst");
    chk("addr_after_rst", 32'(obs_addr), 32'h4000);

    // random traffic
    rand_lat = 1;
    rdy_pct = 75;
    cur = iread_addr;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      r = int'($urandom_range(0, 31));
      if (m_valid_seen) begin
        if (r == 0)      cur = 16'($urandom);
        else if (r == 1) cur = 16'hFFF8 + 16'($urandom_range(0, 7));
        else if (r == 2) cur = cur - 16'($urandom_range(1, 4));
        else if (r >= 8) cur = cur + 16'($urandom_range(1, 3));
      end else if (r == 0) begin
        cur = 16'($urandom);
      end
      iread_addr = cur;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
